whack_button_conditioner: RTL and testbench

//   Input-side front end for the whack-a-mole game core. Takes the 8 raw

---
 rtl/whack_button_conditioner_if.sv | 22 ++
 rtl/whack_button_conditioner.sv | 164 ++++++++++++++++
 tb/tb_whack_button_conditioner.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whack_button_conditioner_if.sv
// Hit-event handshake between the button conditioner (master) and the game core (slave).
interface whack_button_conditioner_if #(
   parameter int N_BTN = 8
) ();
   localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   logic          press_valid;
   logic [IW-1:0] press_idx;
   logic          press_ready;

   modport master (
      output press_valid,
      output press_idx,
      input  press_ready
   );

   modport slave (
      input  press_valid,
      input  press_idx,
      output press_ready
   );
endinterface

// File: rtl/whack_button_conditioner.sv
// Button front end for the whack-a-mole core: synchronise, debounce and queue
// one hit event per debounced press, handed out lowest index first.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing presented; load lowest pending index when any is set
// S_OFFER | press_valid=1, press_idx held until the core takes it
module whack_button_conditioner #(
   parameter int N_BTN     = 8,
   parameter int DB_CYCLES = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_BTN-1:0]                btn_raw,
   input  logic                            arm,
   output logic [N_BTN-1:0]                btn_level,
   whack_button_conditioner_if.master      press,
   output logic [7:0]                      drop_cnt
);
   localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int CW = $clog2(DB_CYCLES);
   localparam int PW = $clog2(N_BTN + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_OFFER = 1'b1;

   logic [N_BTN-1:0] sync_a;
   logic [N_BTN-1:0] sync_b;
   logic [1:0]       fill;
   logic [N_BTN-1:0] live;
   logic [CW-1:0]    cnt   [N_BTN];
   logic [CW-1:0]    cnt_d [N_BTN];
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] pending_d;
   logic [N_BTN-1:0] pop_mask;
   logic [N_BTN-1:0] remain;
   logic [N_BTN-1:0] dropped;
   logic [PW-1:0]    n_drop;
   logic [8:0]       drop_sum;
   logic [7:0]       drop_d;
   logic [0:0]       state;
   logic [0:0]       state_d;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    idx_d;

   function automatic logic [IW-1:0] lowest(input logic [N_BTN-1:0] v);
      lowest = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (v[i]) lowest = IW'(i);
      end
   endfunction

   function automatic logic [PW-1:0] ones(input logic [N_BTN-1:0] v);
      ones = '0;
      for (int i = 0; i < N_BTN; i++) begin
         ones = ones + PW'(v[i]);
      end
   endfunction

   // Two-flop synchroniser; fill marks when sync_b carries real pad samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         fill   <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         fill   <= {fill[0], 1'b1};
      end
   end

   // A channel only produces events once it has been seen released after
   // reset, so a button held through reset stays silent until re-pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live <= '0;
      end else begin
         live <= live | ({N_BTN{fill[1]}} & ~sync_b);
      end
   end

   always_comb begin
      level_d = btn_level;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = cnt[i];
         if (sync_b[i] == btn_level[i]) begin
            cnt_d[i] = '0;
         end else if (cnt[i] == CNT_TC) begin
            level_d[i] = sync_b[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_level <= '0;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else begin
         btn_level <= level_d;
         for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_d[i];
      end
   end

   // A press landing on a bit that is still pending (even one being popped
   // this cycle) is lost and counted.
   always_comb begin
      rise      = level_d & ~btn_level & live & {N_BTN{arm}};
      pop_mask  = (state == S_OFFER && press.press_ready) ? (N_BTN'(1) << idx_q) : '0;
      remain    = pending & ~pop_mask;
      dropped   = rise & pending;
      n_drop    = ones(dropped);
      drop_sum  = {1'b0, drop_cnt} + 9'(n_drop);
      drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      pending_d = arm ? (remain | (rise & ~pending)) : '0;
   end

   always_comb begin
      state_d = state;
      idx_d   = idx_q;
      if (!arm) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (pending != '0) begin
                  state_d = S_OFFER;
                  idx_d   = lowest(pending);
               end
            end
            S_OFFER: begin
               if (press.press_ready) begin
                  if (remain != '0) idx_d = lowest(remain);
                  else              state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         state    <= S_IDLE;
         idx_q    <= '0;
         drop_cnt <= '0;
      end else begin
         pending  <= pending_d;
         state    <= state_d;
         idx_q    <= idx_d;
         drop_cnt <= drop_d;
      end
   end

   assign press.press_valid = (state == S_OFFER);
   assign press.press_idx   = idx_q;
endmodule

// File: tb/tb_whack_button_conditioner.sv
// Bench for whack_button_conditioner with DB_CYCLES=4: vector table, directed
// corner sequences and a randomized run against a history-based reference model.
module tb_whack_button_conditioner;
   localparam int N_BTN = 8;
   localparam int DB    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] btn_raw = '0;
   logic       arm = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] btn_level;
   logic [7:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   whack_button_conditioner_if #(.N_BTN(N_BTN)) pif ();
   assign pif.press_ready = ready;

   whack_button_conditioner #(.N_BTN(N_BTN), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .arm       (arm),
      .btn_level (btn_level),
      .press     (pif.master),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] lvl;
      logic       vld;
      logic [2:0] idx;
   } vec_t;
   vec_t tbl[$];

   // reference model state
   logic [7:0] m_q[$];
   logic [7:0] m_lvl, m_seen, m_pend, m_drop;
   logic       m_valid;
   logic [2:0] m_idx;
   int         m_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int n, input logic [7:0] raw, input logic [7:0] lvl,
                      input logic vld, input logic [2:0] idx);
      vec_t v;
      v.raw = raw; v.lvl = lvl; v.vld = vld; v.idx = idx;
      repeat (n) tbl.push_back(v);
   endtask

   function automatic logic [2:0] low8(input logic [7:0] v);
      logic [2:0] r = 3'd0;
      for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
      return r;
   endfunction

   function automatic int pop8(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic model_reset();
      m_q = {};
      repeat (DB + 2) m_q.push_back(8'h00);
      m_lvl = '0; m_seen = '0; m_pend = '0; m_drop = '0;
      m_valid = 1'b0; m_idx = '0; m_t = 0;
   endtask

   // Level flips once the last DB synchronised samples all disagree with it;
   // the synchronised sample at edge t is the raw value seen two edges earlier.
   task automatic model_step();
      logic [7:0] new_lvl, rise, pop, rem, new_pend;
      logic       nv;
      logic [2:0] ni;
      int         s;
      m_t++;
      new_lvl = m_lvl;
      for (int i = 0; i < 8; i++) begin
         bit all_diff = 1'b1;
         for (int k = 1; k <= DB; k++) if (m_q[k][i] == m_lvl[i]) all_diff = 1'b0;
         if (all_diff) new_lvl[i] = ~m_lvl[i];
      end
      rise = new_lvl & ~m_lvl & m_seen & {8{arm}};
      pop  = (m_valid && ready) ? (8'h01 << m_idx) : 8'h00;
      nv = m_valid; ni = m_idx;
      if (arm) begin
         s = int'(m_drop) + pop8(rise & m_pend);
         m_drop = (s > 255) ? 8'hFF : 8'(s);
         new_pend = (m_pend & ~pop) | (rise & ~m_pend);
         if (!m_valid) begin
            if (m_pend != 0) begin nv = 1'b1; ni = low8(m_pend); end
         end else if (ready) begin
            rem = m_pend & ~pop;
            if (rem != 0) ni = low8(rem);
            else          nv = 1'b0;
         end
      end else begin
         new_pend = '0;
         nv = 1'b0;
      end
      if (m_t >= 3) m_seen = m_seen | ~m_q[1];
      m_q.push_front(btn_raw);
      void'(m_q.pop_back());
      m_lvl = new_lvl; m_pend = new_pend; m_valid = nv; m_idx = ni;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn_raw = '0; arm = 1'b1; ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int hold[8];
      int arm_hold;
      int pulses;

      // reset + held press, glitch, simultaneous press
      add(3, 8'h00, 8'h00, 0, 0);
      add(5, 8'h04, 8'h00, 0, 0);
      add(1, 8'h04, 8'h04, 0, 0);
      add(1, 8'h04, 8'h04, 1, 2);
      add(3, 8'h04, 8'h04, 0, 0);
      add(5, 8'h00, 8'h04, 0, 0);
      add(3, 8'h00, 8'h00, 0, 0);
      add(3, 8'h01, 8'h00, 0, 0);
      add(8, 8'h00, 8'h00, 0, 0);
      add(5, 8'h91, 8'h00, 0, 0);
      add(1, 8'h91, 8'h91, 0, 0);
      add(1, 8'h91, 8'h91, 1, 0);
      add(1, 8'h91, 8'h91, 1, 4);
      add(1, 8'h91, 8'h91, 1, 7);
      add(2, 8'h91, 8'h91, 0, 0);
      add(5, 8'h00, 8'h91, 0, 0);
      add(3, 8'h00, 8'h00, 0, 0);

      rst_n = 1'b0;
      #1;
      chk("reset_level", btn_level, 8'h00);
      chk("reset_valid", {7'b0, pif.press_valid}, 8'h00);
      chk("reset_drop", drop_cnt, 8'h00);
      do_reset();

      for (int n = 0; n < tbl.size(); n++) begin
         btn_raw = tbl[n].raw;
         tick();
         chk($sformatf("tbl%0d_level", n), btn_level, tbl[n].lvl);
         chk($sformatf("tbl%0d_valid", n), {7'b0, pif.press_valid}, {7'b0, tbl[n].vld});
         if (tbl[n].vld) chk($sformatf("tbl%0d_idx", n), {5'b0, pif.press_idx}, {5'b0, tbl[n].idx});
         chk($sformatf("tbl%0d_drop", n), drop_cnt, 8'h00);
      end

      // presented index holds while waiting even when a lower one arrives
      ready = 1'b0;
      btn_raw = 8'h08;
      repeat (6) tick();
      chk("t4_level", btn_level, 8'h08);
      tick();
      chk("t4_valid", {7'b0, pif.press_valid}, 8'h01);
      chk("t4_idx3", {5'b0, pif.press_idx}, 8'h03);
      btn_raw = 8'h0A;
      repeat (8) begin
         tick();
         chk("t4_hold_valid", {7'b0, pif.press_valid}, 8'h01);
         chk("t4_hold_idx", {5'b0, pif.press_idx}, 8'h03);
      end
      ready = 1'b1;
      tick();
      chk("t4_next_valid", {7'b0, pif.press_valid}, 8'h01);
      chk("t4_next_idx1", {5'b0, pif.press_idx}, 8'h01);
      tick();
      chk("t4_done", {7'b0, pif.press_valid}, 8'h00);
      ready = 1'b0;
      btn_raw = 8'h00;
      repeat (8) tick();

      // re-press on a pending bit is dropped
      btn_raw = 8'h20;
      repeat (7) tick();
      chk("t5_idx5", {5'b0, pif.press_idx}, 8'h05);
      chk("t5_valid", {7'b0, pif.press_valid}, 8'h01);
      btn_raw = 8'h00;
      repeat (8) tick();
      chk("t5_release", btn_level, 8'h00);
      btn_raw = 8'h20;
      repeat (8) tick();
      chk("t5_drop", drop_cnt, 8'h01);
      chk("t5_still_idx5", {5'b0, pif.press_idx}, 8'h05);
      ready = 1'b1;
      pulses = 0;
      repeat (6) begin
         tick();
         pulses += int'(pif.press_valid);
      end
      chk("t5_one_event", 8'(pulses), 8'h00);
      btn_raw = 8'h00;
      repeat (8) tick();

      // disarm flushes, reset mid-debounce clears everything
      ready = 1'b0;
      btn_raw = 8'h08;
      repeat (7) tick();
      chk("t6_valid", {7'b0, pif.press_valid}, 8'h01);
      arm = 1'b0;
      tick();
      chk("t6_disarm", {7'b0, pif.press_valid}, 8'h00);
      arm = 1'b1;
      repeat (3) begin
         tick();
         chk("t6_flushed", {7'b0, pif.press_valid}, 8'h00);
      end
      chk("t6_drop_kept", drop_cnt, 8'h01);
      btn_raw = 8'h00;
      repeat (3) tick();
      chk("t6_mid_db", btn_level, 8'h08);
      #2 rst_n = 1'b0;
      btn_raw = 8'h08;
      #1;
      chk("t6_rst_level", btn_level, 8'h00);
      chk("t6_rst_valid", {7'b0, pif.press_valid}, 8'h00);
      chk("t6_rst_idx", {5'b0, pif.press_idx}, 8'h00);
      chk("t6_rst_drop", drop_cnt, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ready = 1'b1;

      // button held through reset: no event until released and re-pressed
      pulses = 0;
      repeat (12) begin
         tick();
         pulses += int'(pif.press_valid);
      end
      chk("held_level", btn_level, 8'h08);
      chk("held_no_event", 8'(pulses), 8'h00);
      btn_raw = 8'h00;
      repeat (8) tick();
      btn_raw = 8'h08;
      repeat (7) tick();
      chk("repress_valid", {7'b0, pif.press_valid}, 8'h01);
      chk("repress_idx", {5'b0, pif.press_idx}, 8'h03);
      btn_raw = 8'h00;
      repeat (8) tick();

      // randomized run against the reference model
      do_reset();
      for (int i = 0; i < 8; i++) hold[i] = int'($urandom_range(3, 12));
      arm_hold = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (hold[i] == 0) begin
               btn_raw[i] = ~btn_raw[i];
               hold[i] = int'($urandom_range(1, 10));
            end else begin
               hold[i]--;
            end
         end
         if (arm_hold > 0) begin
            arm_hold--;
         end else if ($urandom_range(0, 99) == 0) begin
            arm = 1'b0;
            arm_hold = int'($urandom_range(1, 6));
         end else begin
            arm = 1'b1;
         end
         ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_level", btn_level, m_lvl);
         chk("rnd_valid", {7'b0, pif.press_valid}, {7'b0, m_valid});
         if (m_valid) chk("rnd_idx", {5'b0, pif.press_idx}, {5'b0, m_idx});
         chk("rnd_drop", drop_cnt, m_drop);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
